// File: rtl/z80fi_pkg.sv
// Shared definitions for the z80fi instruction trace collector.
// Holds the bus cycle codes, collector states and the mem-slot record layout.
package z80fi_pkg;

    typedef enum logic [2:0] {
        BUS_M1   = 3'd0,
        BUS_MRD  = 3'd1,
        BUS_MWR  = 3'd2,
        BUS_IORD = 3'd3,
        BUS_IOWR = 3'd4
    } bus_kind_t;

    localparam int MAX_MEM_SLOTS = 2;

    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } state_t;

    typedef struct packed {
        logic        used1;
        logic        used2;
        logic        ovf;
        logic [15:0] addr1;
        logic [7:0]  data1;
        logic [15:0] addr2;
        logic [7:0]  data2;
    } mem_slots_t;

endpackage

// File: rtl/z80fi_mem_slots.sv
// Two-entry first/second capture of memory cycles for one direction (read or write).
// slots_d is the next state; it lets the parent retire a packet that includes this cycle's push.
module z80fi_mem_slots
    import z80fi_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic [15:0] addr,
    input  logic [7:0]  data,
    output mem_slots_t  slots_q,
    output mem_slots_t  slots_d
);

    mem_slots_t base;
    logic [1:0] fill;

    always_comb begin
        base    = clear ? '0 : slots_q;
        fill    = {1'b0, base.used1} + {1'b0, base.used2};
        slots_d = base;
        if (push) begin
            if (fill == 2'(MAX_MEM_SLOTS)) begin
                slots_d.ovf = 1'b1;
            end else if (!base.used1) begin
                slots_d.used1 = 1'b1;
                slots_d.addr1 = addr;
                slots_d.data1 = data;
            end else begin
                slots_d.used2 = 1'b1;
                slots_d.addr2 = addr;
                slots_d.data2 = data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slots_q <= '0;
        end else begin
            slots_q <= slots_d;
        end
    end

endmodule

// File: rtl/z80fi_insn_collector.sv
// Assembles one retirement packet per instruction from start/done pulses and bus events.
//   state      | meaning
//   ST_IDLE    | no instruction in flight; bus events and stray done are ignored
//   ST_COLLECT | gathering opcode bytes and mem records for the current instruction
module z80fi_insn_collector
    import z80fi_pkg::*;
#(
    parameter int MAX_INSN_BYTES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          insn_start,
    input  logic                          insn_done,
    input  logic                          bus_ev,
    input  logic [2:0]                    bus_kind,
    input  logic [15:0]                   bus_addr,
    input  logic [7:0]                    bus_data,
    input  logic [15:0]                   reg_ip,
    input  logic [15:0]                   reg_sp,
    input  logic                          reg_iff1,
    input  logic                          reg_iff2,
    output logic                          z80fi_valid,
    output logic [8*MAX_INSN_BYTES-1:0]   z80fi_insn,
    output logic [2:0]                    z80fi_insn_len,
    output logic [15:0]                   z80fi_mem_raddr,
    output logic [15:0]                   z80fi_mem_raddr2,
    output logic [7:0]                    z80fi_mem_rdata,
    output logic [7:0]                    z80fi_mem_rdata2,
    output logic [15:0]                   z80fi_mem_waddr,
    output logic [15:0]                   z80fi_mem_waddr2,
    output logic [7:0]                    z80fi_mem_wdata,
    output logic [7:0]                    z80fi_mem_wdata2,
    output logic                          z80fi_mem_rd,
    output logic                          z80fi_mem_rd2,
    output logic                          z80fi_mem_wr,
    output logic                          z80fi_mem_wr2,
    output logic [15:0]                   z80fi_reg_ip_in,
    output logic [15:0]                   z80fi_reg_ip_out,
    output logic [15:0]                   z80fi_reg_sp_in,
    output logic [15:0]                   z80fi_reg_sp_out,
    output logic                          z80fi_reg_iff1_in,
    output logic                          z80fi_reg_iff1_out,
    output logic                          z80fi_reg_iff2_in,
    output logic                          z80fi_reg_iff2_out,
    output logic                          z80fi_overflow
);

    localparam logic [2:0] MAX_LEN = 3'(MAX_INSN_BYTES);

    state_t state_q, state_d;
    logic   collecting, done_ok;
    logic   push_m1, push_rd, push_wr;

    logic [8*MAX_INSN_BYTES-1:0] insn_q, insn_d;
    logic [2:0]  len_q, len_d;
    logic        op_ovf_q, op_ovf_d;
    logic [15:0] ip_in_q, sp_in_q;
    logic        iff1_in_q, iff2_in_q;

    mem_slots_t rd_q, rd_d, wr_q, wr_d;
    mem_slots_t rd_pkt, wr_pkt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        collecting = 1'b0;
        done_ok    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                collecting = insn_start;
                if (insn_start) state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                collecting = 1'b1;
                done_ok    = insn_done;
                if (insn_done && !insn_start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign push_m1 = bus_ev && collecting && (bus_kind == BUS_M1);
    assign push_rd = bus_ev && collecting && (bus_kind == BUS_MRD);
    assign push_wr = bus_ev && collecting && (bus_kind == BUS_MWR);

    // A new start wipes the buffer first, so a same-cycle fetch lands at byte 0.
    always_comb begin
        insn_d   = insn_start ? '0 : insn_q;
        len_d    = insn_start ? 3'd0 : len_q;
        op_ovf_d = insn_start ? 1'b0 : op_ovf_q;
        if (push_m1) begin
            if (len_d < MAX_LEN) begin
                for (int i = 0; i < MAX_INSN_BYTES; i++) begin
                    if (len_d == 3'(i)) insn_d[i*8 +: 8] = bus_data;
                end
                len_d = len_d + 3'd1;
            end else begin
                op_ovf_d = 1'b1;
            end
        end
    end

    z80fi_mem_slots u_rd_slots (
        .clk     (clk),
        .reset   (reset),
        .clear   (insn_start),
        .push    (push_rd),
        .addr    (bus_addr),
        .data    (bus_data),
        .slots_q (rd_q),
        .slots_d (rd_d)
    );

    z80fi_mem_slots u_wr_slots (
        .clk     (clk),
        .reset   (reset),
        .clear   (insn_start),
        .push    (push_wr),
        .addr    (bus_addr),
        .data    (bus_data),
        .slots_q (wr_q),
        .slots_d (wr_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            insn_q    <= '0;
            len_q     <= '0;
            op_ovf_q  <= 1'b0;
            ip_in_q   <= '0;
            sp_in_q   <= '0;
            iff1_in_q <= 1'b0;
            iff2_in_q <= 1'b0;
        end else begin
            insn_q   <= insn_d;
            len_q    <= len_d;
            op_ovf_q <= op_ovf_d;
            if (insn_start) begin
                ip_in_q   <= reg_ip;
                sp_in_q   <= reg_sp;
                iff1_in_q <= reg_iff1;
                iff2_in_q <= reg_iff2;
            end
        end
    end

    // On done+start the bus event belongs to the next instruction, so retire the old registered view.
    assign rd_pkt = insn_start ? rd_q : rd_d;
    assign wr_pkt = insn_start ? wr_q : wr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            z80fi_valid        <= 1'b0;
            z80fi_insn         <= '0;
            z80fi_insn_len     <= '0;
            z80fi_mem_raddr    <= '0;
            z80fi_mem_raddr2   <= '0;
            z80fi_mem_rdata    <= '0;
            z80fi_mem_rdata2   <= '0;
            z80fi_mem_waddr    <= '0;
            z80fi_mem_waddr2   <= '0;
            z80fi_mem_wdata    <= '0;
            z80fi_mem_wdata2   <= '0;
            z80fi_mem_rd       <= 1'b0;
            z80fi_mem_rd2      <= 1'b0;
            z80fi_mem_wr       <= 1'b0;
            z80fi_mem_wr2      <= 1'b0;
            z80fi_reg_ip_in    <= '0;
            z80fi_reg_ip_out   <= '0;
            z80fi_reg_sp_in    <= '0;
            z80fi_reg_sp_out   <= '0;
            z80fi_reg_iff1_in  <= 1'b0;
            z80fi_reg_iff1_out <= 1'b0;
            z80fi_reg_iff2_in  <= 1'b0;
            z80fi_reg_iff2_out <= 1'b0;
            z80fi_overflow     <= 1'b0;
        end else begin
            z80fi_valid <= done_ok;
            if (done_ok) begin
                z80fi_insn         <= insn_start ? insn_q : insn_d;
                z80fi_insn_len     <= insn_start ? len_q : len_d;
                z80fi_overflow     <= (insn_start ? op_ovf_q : op_ovf_d) | rd_pkt.ovf | wr_pkt.ovf;
                z80fi_mem_raddr    <= rd_pkt.addr1;
                z80fi_mem_rdata    <= rd_pkt.data1;
                z80fi_mem_raddr2   <= rd_pkt.addr2;
                z80fi_mem_rdata2   <= rd_pkt.data2;
                z80fi_mem_rd       <= rd_pkt.used1;
                z80fi_mem_rd2      <= rd_pkt.used2;
                z80fi_mem_waddr    <= wr_pkt.addr1;
                z80fi_mem_wdata    <= wr_pkt.data1;
                z80fi_mem_waddr2   <= wr_pkt.addr2;
                z80fi_mem_wdata2   <= wr_pkt.data2;
                z80fi_mem_wr       <= wr_pkt.used1;
                z80fi_mem_wr2      <= wr_pkt.used2;
                z80fi_reg_ip_in    <= ip_in_q;
                z80fi_reg_sp_in    <= sp_in_q;
                z80fi_reg_iff1_in  <= iff1_in_q;
                z80fi_reg_iff2_in  <= iff2_in_q;
                z80fi_reg_ip_out   <= reg_ip;
                z80fi_reg_sp_out   <= reg_sp;
                z80fi_reg_iff1_out <= reg_iff1;
                z80fi_reg_iff2_out <= reg_iff2;
            end
        end
    end

endmodule

// File: tb/tb_z80fi_insn_collector.sv
// Scoreboard bench for z80fi_insn_collector: directed traces push expected packets,
// a negedge monitor pops and compares each retirement.
module tb_z80fi_insn_collector;
    import z80fi_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        insn_start = 1'b0, insn_done = 1'b0, bus_ev = 1'b0;
    logic [2:0]  bus_kind = 3'd0;
    logic [15:0] bus_addr = 16'd0;
    logic [7:0]  bus_data = 8'd0;
    logic [15:0] reg_ip = 16'd0, reg_sp = 16'd0;
    logic        reg_iff1 = 1'b0, reg_iff2 = 1'b0;

    logic        z80fi_valid;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [15:0] z80fi_mem_raddr, z80fi_mem_raddr2, z80fi_mem_waddr, z80fi_mem_waddr2;
    logic [7:0]  z80fi_mem_rdata, z80fi_mem_rdata2, z80fi_mem_wdata, z80fi_mem_wdata2;
    logic        z80fi_mem_rd, z80fi_mem_rd2, z80fi_mem_wr, z80fi_mem_wr2;
    logic [15:0] z80fi_reg_ip_in, z80fi_reg_ip_out, z80fi_reg_sp_in, z80fi_reg_sp_out;
    logic        z80fi_reg_iff1_in, z80fi_reg_iff1_out, z80fi_reg_iff2_in, z80fi_reg_iff2_out;
    logic        z80fi_overflow;

    z80fi_insn_collector #(.MAX_INSN_BYTES(4)) dut (
        .clk(clk), .reset(reset),
        .insn_start(insn_start), .insn_done(insn_done),
        .bus_ev(bus_ev), .bus_kind(bus_kind), .bus_addr(bus_addr), .bus_data(bus_data),
        .reg_ip(reg_ip), .reg_sp(reg_sp), .reg_iff1(reg_iff1), .reg_iff2(reg_iff2),
        .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
        .z80fi_mem_raddr(z80fi_mem_raddr), .z80fi_mem_raddr2(z80fi_mem_raddr2),
        .z80fi_mem_rdata(z80fi_mem_rdata), .z80fi_mem_rdata2(z80fi_mem_rdata2),
        .z80fi_mem_waddr(z80fi_mem_waddr), .z80fi_mem_waddr2(z80fi_mem_waddr2),
        .z80fi_mem_wdata(z80fi_mem_wdata), .z80fi_mem_wdata2(z80fi_mem_wdata2),
        .z80fi_mem_rd(z80fi_mem_rd), .z80fi_mem_rd2(z80fi_mem_rd2),
        .z80fi_mem_wr(z80fi_mem_wr), .z80fi_mem_wr2(z80fi_mem_wr2),
        .z80fi_reg_ip_in(z80fi_reg_ip_in), .z80fi_reg_ip_out(z80fi_reg_ip_out),
        .z80fi_reg_sp_in(z80fi_reg_sp_in), .z80fi_reg_sp_out(z80fi_reg_sp_out),
        .z80fi_reg_iff1_in(z80fi_reg_iff1_in), .z80fi_reg_iff1_out(z80fi_reg_iff1_out),
        .z80fi_reg_iff2_in(z80fi_reg_iff2_in), .z80fi_reg_iff2_out(z80fi_reg_iff2_out),
        .z80fi_overflow(z80fi_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] insn;
        logic [2:0]  len;
        logic [15:0] raddr, raddr2, waddr, waddr2;
        logic [7:0]  rdata, rdata2, wdata, wdata2;
        logic        rd, rd2, wr, wr2;
        logic [15:0] ip_in, ip_out, sp_in, sp_out;
        logic        iff1_in, iff1_out, iff2_in, iff2_out;
        logic        ovf;
    } pkt_t;

    pkt_t exp_q[$];
    pkt_t e;
    int   checks = 0;
    int   errors = 0;
    int   npkt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic clr_e();
        e = '{default: '0};
    endtask

    task automatic step(input logic s, input logic d, input logic ev,
                        input logic [2:0] k, input logic [15:0] a, input logic [7:0] dat);
        insn_start = s;
        insn_done  = d;
        bus_ev     = ev;
        bus_kind   = k;
        bus_addr   = a;
        bus_data   = dat;
        @(posedge clk);
        #1;
        insn_start = 1'b0;
        insn_done  = 1'b0;
        bus_ev     = 1'b0;
        bus_kind   = 3'd0;
        bus_addr   = 16'd0;
        bus_data   = 8'd0;
    endtask

    task automatic m1(input logic [7:0] op);
        step(1'b0, 1'b0, 1'b1, BUS_M1, 16'h0000, op);
    endtask

    task automatic setregs(input logic [15:0] ip, input logic [15:0] sp, input logic i1, input logic i2);
        reg_ip = ip; reg_sp = sp; reg_iff1 = i1; reg_iff2 = i2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every valid must match the oldest expected packet.
    always @(negedge clk) begin
        pkt_t m;
        if (!reset && z80fi_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid=1 expected no packet (insn=%h)", z80fi_insn);
            end else begin
                m = exp_q.pop_front();
                npkt++;
                chk($sformatf("p%0d insn", npkt), z80fi_insn, m.insn);
                chk($sformatf("p%0d len", npkt), 32'(z80fi_insn_len), 32'(m.len));
                chk($sformatf("p%0d rd1", npkt), {z80fi_mem_rd, 7'd0, z80fi_mem_raddr, z80fi_mem_rdata},
                    {m.rd, 7'd0, m.raddr, m.rdata});
                chk($sformatf("p%0d rd2", npkt), {z80fi_mem_rd2, 7'd0, z80fi_mem_raddr2, z80fi_mem_rdata2},
                    {m.rd2, 7'd0, m.raddr2, m.rdata2});
                chk($sformatf("p%0d wr1", npkt), {z80fi_mem_wr, 7'd0, z80fi_mem_waddr, z80fi_mem_wdata},
                    {m.wr, 7'd0, m.waddr, m.wdata});
                chk($sformatf("p%0d wr2", npkt), {z80fi_mem_wr2, 7'd0, z80fi_mem_waddr2, z80fi_mem_wdata2},
                    {m.wr2, 7'd0, m.waddr2, m.wdata2});
                chk($sformatf("p%0d ip", npkt), {z80fi_reg_ip_in, z80fi_reg_ip_out}, {m.ip_in, m.ip_out});
                chk($sformatf("p%0d sp", npkt), {z80fi_reg_sp_in, z80fi_reg_sp_out}, {m.sp_in, m.sp_out});
                chk($sformatf("p%0d iff", npkt),
                    {28'd0, z80fi_reg_iff1_in, z80fi_reg_iff1_out, z80fi_reg_iff2_in, z80fi_reg_iff2_out},
                    {28'd0, m.iff1_in, m.iff1_out, m.iff2_in, m.iff2_out});
                chk($sformatf("p%0d ovf", npkt), 32'(z80fi_overflow), 32'(m.ovf));
            end
        end
    end

    initial begin
        do_reset();
        do_reset();
        chk("reset_valid", 32'(z80fi_valid), 32'd0);
        chk("reset_insn", z80fi_insn, 32'd0);
        chk("reset_len_ovf", {z80fi_insn_len, z80fi_overflow, z80fi_mem_rd, z80fi_mem_wr}, 32'd0);
        chk("reset_regs", {z80fi_reg_ip_out, z80fi_reg_sp_out}, 32'd0);

        // RETN
        setregs(16'h0100, 16'hFFF0, 1'b0, 1'b1);
        step(1, 0, 0, 3'd0, 16'h0, 8'h0);
        m1(8'hED);
        m1(8'h45);
        step(0, 0, 1, BUS_MRD, 16'hFFF0, 8'h34);
        step(0, 0, 1, BUS_MRD, 16'hFFF1, 8'h12);
        setregs(16'h1234, 16'hFFF2, 1'b1, 1'b1);
        clr_e();
        e.insn = 32'h0000_45ED; e.len = 3'd2;
        e.raddr = 16'hFFF0; e.rdata = 8'h34; e.raddr2 = 16'hFFF1; e.rdata2 = 8'h12;
        e.rd = 1; e.rd2 = 1;
        e.ip_in = 16'h0100; e.sp_in = 16'hFFF0; e.iff1_in = 0; e.iff2_in = 1;
        e.ip_out = 16'h1234; e.sp_out = 16'hFFF2; e.iff1_out = 1; e.iff2_out = 1;
        exp_q.push_back(e);
        step(0, 1, 0, 3'd0, 16'h0, 8'h0);
        step(0, 0, 0, 3'd0, 16'h0, 8'h0);

        // PUSH BC: fetch with start, second write with done
        setregs(16'h0200, 16'h2000, 1'b1, 1'b1);
        step(1, 0, 1, BUS_M1, 16'h0200, 8'hC5);
        step(0, 0, 1, BUS_MWR, 16'h1FFF, 8'hAB);
        setregs(16'h0201, 16'h1FFE, 1'b1, 1'b1);
        clr_e();
        e.insn = 32'h0000_00C5; e.len = 3'd1;
        e.waddr = 16'h1FFF; e.wdata = 8'hAB; e.waddr2 = 16'h1FFE; e.wdata2 = 8'hCD;
        e.wr = 1; e.wr2 = 1;
        e.ip_in = 16'h0200; e.sp_in = 16'h2000; e.iff1_in = 1; e.iff2_in = 1;
        e.ip_out = 16'h0201; e.sp_out = 16'h1FFE; e.iff1_out = 1; e.iff2_out = 1;
        exp_q.push_back(e);
        step(0, 1, 1, BUS_MWR, 16'h1FFE, 8'hCD);
        step(0, 0, 0, 3'd0, 16'h0, 8'h0);

        // Back-to-back: LD A,77 then NOP, done+start+fetch in one cycle
        setregs(16'h0300, 16'h3000, 1'b0, 1'b0);
        step(1, 0, 0, 3'd0, 16'h0, 8'h0);
        m1(8'h3E);
        m1(8'h77);
        setregs(16'h0302, 16'h3000, 1'b0, 1'b0);
        clr_e();
        e.insn = 32'h0000_773E; e.len = 3'd2;
        e.ip_in = 16'h0300; e.sp_in = 16'h3000; e.ip_out = 16'h0302; e.sp_out = 16'h3000;
        exp_q.push_back(e);
        step(1, 1, 1, BUS_M1, 16'h0302, 8'h00);
        setregs(16'h0303, 16'h3000, 1'b0, 1'b0);
        clr_e();
        e.insn = 32'h0; e.len = 3'd1;
        e.ip_in = 16'h0302; e.sp_in = 16'h3000; e.ip_out = 16'h0303; e.sp_out = 16'h3000;
        exp_q.push_back(e);
        step(0, 1, 0, 3'd0, 16'h0, 8'h0);
        step(0, 0, 0, 3'd0, 16'h0, 8'h0);

        // Opcode overflow: five fetches
        setregs(16'h0400, 16'h4000, 1'b1, 1'b0);
        step(1, 0, 0, 3'd0, 16'h0, 8'h0);
        m1(8'hDD); m1(8'hCB); m1(8'h05); m1(8'hC6); m1(8'h11);
        clr_e();
        e.insn = 32'hC605_CBDD; e.len = 3'd4; e.ovf = 1;
        e.ip_in = 16'h0400; e.sp_in = 16'h4000; e.iff1_in = 1;
        e.ip_out = 16'h0400; e.sp_out = 16'h4000; e.iff1_out = 1;
        exp_q.push_back(e);
        step(0, 1, 0, 3'd0, 16'h0, 8'h0);
        step(0, 0, 0, 3'd0, 16'h0, 8'h0);

        // Read slot overflow: three reads
        setregs(16'h0410, 16'h4100, 1'b0, 1'b1);
        step(1, 0, 0, 3'd0, 16'h0, 8'h0);
        m1(8'hED);
        step(0, 0, 1, BUS_MRD, 16'h4000, 8'h01);
        step(0, 0, 1, BUS_MRD, 16'h4001, 8'h02);
        step(0, 0, 1, BUS_MRD, 16'h4002, 8'h03);
        clr_e();
        e.insn = 32'h0000_00ED; e.len = 3'd1; e.ovf = 1;
        e.raddr = 16'h4000; e.rdata = 8'h01; e.raddr2 = 16'h4001; e.rdata2 = 8'h02;
        e.rd = 1; e.rd2 = 1;
        e.ip_in = 16'h0410; e.sp_in = 16'h4100; e.iff2_in = 1;
        e.ip_out = 16'h0410; e.sp_out = 16'h4100; e.iff2_out = 1;
        exp_q.push_back(e);
        step(0, 1, 0, 3'd0, 16'h0, 8'h0);
        step(0, 0, 0, 3'd0, 16'h0, 8'h0);

        // Abandon: second start without done restarts collection
        setregs(16'h0600, 16'h6000, 1'b0, 1'b0);
        step(1, 0, 0, 3'd0, 16'h0, 8'h0);
        m1(8'h01);
        step(0, 0, 1, BUS_MWR, 16'h5555, 8'h99);
        setregs(16'h0610, 16'h6000, 1'b0, 1'b0);
        step(1, 0, 0, 3'd0, 16'h0, 8'h0);
        m1(8'h00);
        setregs(16'h0611, 16'h6000, 1'b0, 1'b0);
        clr_e();
        e.insn = 32'h0; e.len = 3'd1;
        e.ip_in = 16'h0610; e.sp_in = 16'h6000; e.ip_out = 16'h0611; e.sp_out = 16'h6000;
        exp_q.push_back(e);
        step(0, 1, 0, 3'd0, 16'h0, 8'h0);
        step(0, 0, 0, 3'd0, 16'h0, 8'h0);

        // Reset between first and second fetch, then a clean NOP
        setregs(16'h0700, 16'h7000, 1'b1, 1'b1);
        step(1, 0, 0, 3'd0, 16'h0, 8'h0);
        m1(8'hED);
        do_reset();
        chk("midreset_clear", {z80fi_valid, z80fi_insn_len, z80fi_insn[27:0]}, 32'd0);
        m1(8'h45);
        step(0, 1, 0, 3'd0, 16'h0, 8'h0);
        step(0, 0, 0, 3'd0, 16'h0, 8'h0);
        setregs(16'h0800, 16'h7000, 1'b1, 1'b1);
        step(1, 0, 1, BUS_M1, 16'h0800, 8'h00);
        setregs(16'h0801, 16'h7000, 1'b1, 1'b1);
        clr_e();
        e.insn = 32'h0; e.len = 3'd1;
        e.ip_in = 16'h0800; e.sp_in = 16'h7000; e.iff1_in = 1; e.iff2_in = 1;
        e.ip_out = 16'h0801; e.sp_out = 16'h7000; e.iff1_out = 1; e.iff2_out = 1;
        exp_q.push_back(e);
        step(0, 1, 0, 3'd0, 16'h0, 8'h0);
        step(0, 0, 0, 3'd0, 16'h0, 8'h0);

        // Stray done in IDLE, then IN A,(n) with io cycles
        step(0, 1, 0, 3'd0, 16'h0, 8'h0);
        step(0, 0, 0, 3'd0, 16'h0, 8'h0);
        setregs(16'h0500, 16'h5000, 1'b1, 1'b0);
        step(1, 0, 0, 3'd0, 16'h0, 8'h0);
        m1(8'hDB);
        m1(8'h10);
        step(0, 0, 1, BUS_IORD, 16'h0010, 8'h55);
        step(0, 0, 1, BUS_IOWR, 16'h0011, 8'h66);
        setregs(16'h0502, 16'h5000, 1'b1, 1'b0);
        clr_e();
        e.insn = 32'h0000_10DB; e.len = 3'd2;
        e.ip_in = 16'h0500; e.sp_in = 16'h5000; e.iff1_in = 1;
        e.ip_out = 16'h0502; e.sp_out = 16'h5000; e.iff1_out = 1;
        exp_q.push_back(e);
        step(0, 1, 1, BUS_IORD, 16'h0012, 8'h77);
        repeat (4) step(0, 0, 0, 3'd0, 16'h0, 8'h0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("packet_count", 32'(npkt), 32'd9);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
